io_input_unit: RTL and testbench

- Memory-mapped input peripheral that produces the 16-bit IO read data consumed by the register write-back mux.
- Synchronizes and debounces 16 board switches and 5 push buttons.
- Latches button-press events in sticky bits that clear on read.
- Presents the selected register on io_rdata combinationally in the same cycle ioRead is asserted, so a load from IO completes in one CPU cycle.

---
 rtl/io_input_unit_if.sv | 16 +
 rtl/io_input_unit.sv | 124 ++++++++++++
 tb/tb_io_input_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/io_input_unit_if.sv
// CPU-side IO read bus for the input peripheral.
//   ioRead   : read strobe from the controller (level, one per CPU cycle)
//   io_addr  : low byte of the ALU-computed address
//   io_rdata : read data returned combinationally to the write-back mux
// Handshake: there is no valid/ready pair. ioRead is a level that acts as
// "valid" for one clock cycle. The peripheral is always ready, so io_rdata
// is valid in the same cycle that ioRead is high, with no wait states.
`timescale 1ns/1ps
interface io_input_unit_if;
  logic        ioRead;
  logic [7:0]  io_addr;
  logic [15:0] io_rdata;

  modport master (output ioRead, output io_addr, input io_rdata);
  modport slave  (input ioRead, input io_addr, output io_rdata);
endinterface

// File: rtl/io_input_unit.sv
// Memory-mapped input peripheral. It synchronizes and debounces 16 board
// switches and 5 push buttons. It latches button presses in sticky event bits
// that clear when read, and it presents the selected register combinationally
// on the IO read bus.
// Ports:
//   clock     : system clock; all state updates on the rising edge
//   reset     : asynchronous, active-high reset
//   bus       : IO read bus (slave side): ioRead, io_addr in; io_rdata out
//   switch_in : raw board switches (asynchronous)
//   button_in : raw push buttons, active-high (asynchronous)
`timescale 1ns/1ps
module io_input_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter logic [7:0]  ADDR_SW         = 8'h70,
  parameter logic [7:0]  ADDR_BTN        = 8'h72,
  parameter logic [7:0]  ADDR_EVT        = 8'h74
) (
  input  logic              clock,
  input  logic              reset,
  io_input_unit_if.slave    bus,
  input  logic [15:0]       switch_in,
  input  logic [4:0]        button_in
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [15:0] sw_meta, sw_sync, sw_sync_d, sw_stable;
  logic [19:0] sw_cnt;
  logic [4:0]  btn_meta, btn_sync, btn_stable, btn_evt;
  logic [19:0] btn_cnt [5];

  logic [19:0] btn_cnt_nxt [5];
  logic [4:0]  btn_stable_nxt;
  logic [4:0]  btn_rise;
  logic [4:0]  evt_clr;
  logic [15:0] rdata;

  // Two-flop synchronizers. sw_sync_d lets the switch debouncer treat any
  // change of the whole 16-bit word as a restart of its shared counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_sync_d <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
    end else begin
      sw_meta   <= switch_in;
      sw_sync   <= sw_meta;
      sw_sync_d <= sw_sync;
      btn_meta  <= button_in;
      btn_sync  <= btn_meta;
    end
  end

  // Switch debounce. One counter serves all 16 switches. The new word is
  // accepted only after it has differed from sw_stable and stayed unchanged
  // for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cnt    <= '0;
      sw_stable <= '0;
    end else if ((sw_sync == sw_stable) || (sw_sync != sw_sync_d)) begin
      sw_cnt <= '0;
    end else if (sw_cnt == CNT_LAST) begin
      sw_stable <= sw_sync;
      sw_cnt    <= '0;
    end else begin
      sw_cnt <= sw_cnt + 20'd1;
    end
  end

  // Button debounce. Each button has its own counter. The counter runs while
  // the synchronized level differs from the accepted level.
  always_comb begin
    btn_cnt_nxt    = '{default: '0};
    btn_stable_nxt = btn_stable;
    for (int i = 0; i < 5; i++) begin
      if (btn_sync[i] != btn_stable[i]) begin
        if (btn_cnt[i] == CNT_LAST) begin
          btn_stable_nxt[i] = ~btn_stable[i];
        end else begin
          btn_cnt_nxt[i] = btn_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign btn_rise = btn_stable_nxt & ~btn_stable;

  // A read of the event register clears exactly the bits it returned. A rise
  // on the same edge is OR-ed in afterwards, so the new press is not lost.
  assign evt_clr = (bus.ioRead && (bus.io_addr == ADDR_EVT)) ? btn_evt : 5'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_cnt    <= '{default: '0};
      btn_stable <= '0;
      btn_evt    <= '0;
    end else begin
      btn_cnt    <= btn_cnt_nxt;
      btn_stable <= btn_stable_nxt;
      btn_evt    <= (btn_evt & ~evt_clr) | btn_rise;
    end
  end

  // Combinational read mux. No wait states, so a load from IO completes in
  // one CPU cycle.
  always_comb begin
    rdata = 16'h0000;
    if (bus.ioRead) begin
      if (bus.io_addr == ADDR_SW) begin
        rdata = sw_stable;
      end else if (bus.io_addr == ADDR_BTN) begin
        rdata = {11'b0, btn_stable};
      end else if (bus.io_addr == ADDR_EVT) begin
        rdata = {11'b0, btn_evt};
      end
    end
  end

  assign bus.io_rdata = rdata;

endmodule

// File: tb/tb_io_input_unit.sv
`timescale 1ns/1ps
module tb_io_input_unit;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switch_in;
  logic [4:0]  button_in;
  always #5 clock = ~clock;

  io_input_unit_if bus ();

  io_input_unit #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .switch_in (switch_in),
    .button_in (button_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Sliding-window view of the debounce rules. A switch word is accepted
  // once the last D+1 synchronized samples agree and differ from the
  // accepted word. A button bit flips once its last D synchronized samples
  // all differ from the accepted level.
  logic [15:0] m_sw_meta, m_sw_sync, m_sw_stable;
  logic [4:0]  m_btn_meta, m_btn_sync, m_btn_stable, m_evt;
  logic [15:0] sw_win[$];
  logic [4:0]  btn_win[$];

  task automatic model_reset();
    m_sw_meta = '0; m_sw_sync = '0; m_sw_stable = '0;
    m_btn_meta = '0; m_btn_sync = '0; m_btn_stable = '0; m_evt = '0;
    sw_win = {};
    btn_win = {};
    for (int k = 0; k < D + 1; k++) sw_win.push_back(16'h0);
    for (int k = 0; k < D; k++) btn_win.push_back(5'h0);
  endtask

  task automatic model_step();
    logic       same;
    logic       flip;
    logic [4:0] nstable;
    logic [4:0] rise;
    sw_win.push_back(m_sw_sync);
    void'(sw_win.pop_front());
    same = 1'b1;
    foreach (sw_win[k]) if (sw_win[k] != sw_win[0]) same = 1'b0;
    if (same && (sw_win[0] != m_sw_stable)) m_sw_stable = sw_win[0];

    btn_win.push_back(m_btn_sync);
    void'(btn_win.pop_front());
    nstable = m_btn_stable;
    for (int i = 0; i < 5; i++) begin
      flip = 1'b1;
      foreach (btn_win[k]) if (btn_win[k][i] == m_btn_stable[i]) flip = 1'b0;
      if (flip) nstable[i] = ~m_btn_stable[i];
    end
    rise = nstable & ~m_btn_stable;
    if (bus.ioRead && (bus.io_addr == 8'h74)) m_evt = rise;
    else m_evt = m_evt | rise;
    m_btn_stable = nstable;

    m_sw_sync  = m_sw_meta;  m_sw_meta  = switch_in;
    m_btn_sync = m_btn_meta; m_btn_meta = button_in;
  endtask

  function automatic logic [15:0] model_rdata();
    if (reset || !bus.ioRead) return 16'h0000;
    case (bus.io_addr)
      8'h70:   return m_sw_stable;
      8'h72:   return {11'b0, m_btn_stable};
      8'h74:   return {11'b0, m_evt};
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: the model advances on the same edge as the DUT. The DUT
  // output is then compared at the falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    @(negedge clock);
    exp_q.push_back(model_rdata());
    check("model", bus.io_rdata, exp_q.pop_front());
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [15:0] exp);
    bus.ioRead  = 1'b1;
    bus.io_addr = a;
    #1;
    check(tag, bus.io_rdata, exp);
  endtask

  task automatic set_read(input logic rd, input logic [7:0] a);
    bus.ioRead  = rd;
    bus.io_addr = a;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] addr_tbl [5];
    reset = 1'b1;
    switch_in = '0;
    button_in = '0;
    set_read(1'b0, 8'h00);
    model_reset();
    repeat (2) @(negedge clock);

    // Reset state.
    peek("rst_sw", 8'h70, 16'h0000);
    peek("rst_btn", 8'h72, 16'h0000);
    peek("rst_evt", 8'h74, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // 1: switch word is accepted on the 7th edge after the raw change.
    switch_in = 16'hA5C3;
    set_read(1'b1, 8'h70);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("t1_cyc%0d", c), bus.io_rdata, (c >= 7) ? 16'hA5C3 : 16'h0000);
    end

    // 2: a 3-cycle glitch on button 2 never reaches the stable level.
    set_read(1'b0, 8'h00);
    button_in = 5'b00100;
    repeat (3) tick();
    button_in = 5'b00000;
    repeat (6) tick();
    peek("t2_btn", 8'h72, 16'h0000);
    peek("t2_evt", 8'h74, 16'h0000);

    // 3: a held button sets its event bit. The read clears the event bit
    //    but not the level.
    set_read(1'b0, 8'h00);
    button_in = 5'b00001;
    repeat (10) tick();
    peek("t3_btn", 8'h72, 16'h0001);
    peek("t3_evt", 8'h74, 16'h0001);
    tick();
    check("t3_evt_clr", bus.io_rdata, 16'h0000);
    peek("t3_btn_hold", 8'h72, 16'h0001);

    // 4: a new rise on button 4 lands on the same edge as a clearing read.
    set_read(1'b0, 8'h00);
    button_in = 5'b00011;
    repeat (8) tick();
    button_in = 5'b10011;
    repeat (5) tick();
    peek("t4_evt_pre", 8'h74, 16'h0002);
    tick();
    check("t4_evt_post", bus.io_rdata, 16'h0010);

    // 6: an idle bus and an unmapped address read zero and leave the events alone.
    set_read(1'b0, 8'h74);
    #1;
    check("t6_idle", bus.io_rdata, 16'h0000);
    tick();
    peek("t6_unmapped", 8'h76, 16'h0000);
    tick();
    peek("t6_evt_kept", 8'h74, 16'h0010);
    set_read(1'b0, 8'h00);

    // 5: a reset pulse aborts debounce. The full delay applies again after release.
    switch_in = 16'hFFFF;
    set_read(1'b1, 8'h70);
    repeat (10) tick();
    check("t5_settled", bus.io_rdata, 16'hFFFF);
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_in_reset", bus.io_rdata, 16'h0000);
    tick();
    reset = 1'b0;
    for (int c = 1; c <= D + 3; c++) begin
      tick();
      check($sformatf("t5_cyc%0d", c), bus.io_rdata, (c >= D + 3) ? 16'hFFFF : 16'h0000);
    end

    // Random: held inputs of random length mixed with random reads.
    addr_tbl[0] = 8'h70; addr_tbl[1] = 8'h72; addr_tbl[2] = 8'h74;
    addr_tbl[3] = 8'h76; addr_tbl[4] = 8'h00;
    for (int it = 0; it < 60; it++) begin
      switch_in = ($urandom_range(0, 3) == 0) ? switch_in : 16'($urandom);
      button_in = 5'($urandom);
      repeat ($urandom_range(1, 9)) begin
        addr_tbl[4] = 8'($urandom);
        set_read(1'($urandom_range(0, 1)), addr_tbl[$urandom_range(0, 4)]);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
